// File: rtl/bcd_seg_display.sv
// rtl/bcd_seg_display.sv - binary to BCD converter with multiplexed 7-segment scanner
module bcd_seg_display #(
  parameter int N          = 2,
  parameter int DIGITS     = 3,
  parameter int SCAN_DIV   = 50_000,
  parameter int ACTIVE_LOW = 1,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          value,
  input  logic                  load,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  ovf,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  // Decimal digits needed for 2^N-1 (floor(N*log10(2))+1); scratch holds the
  // full result so overflow never depends on truncated BCD.
  localparam int NDEC  = (N * 30103) / 100000 + 1;
  localparam int SN    = (NDEC > DIGITS) ? NDEC : DIGITS;
  localparam int SW    = 4 * SN;
  localparam int BW    = 4 * DIGITS;
  localparam int CW    = $clog2(N + 1);
  localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int LIMIT = 10 ** DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N-1:0]      r_shift;
  logic [SW-1:0]     r_scratch;
  logic [SW-1:0]     w_adj;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf_pend;
  logic [BW-1:0]     r_bcd;
  logic              r_ovf;
  logic [63:0]       w_value_ext;
  logic              w_ovf_in;

  logic [PW-1:0]     r_presc;
  logic [IW-1:0]     r_idx;
  logic [DIGITS-1:0] w_lz;
  logic              w_zero_run;
  logic [3:0]        w_nib;
  logic [DIGITS-1:0] w_an_oh;
  logic              w_cur_lz;
  logic [6:0]        w_seg_hi;
  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_an;

  assign w_value_ext = 64'(value);
  assign w_ovf_in    = (w_value_ext >= 64'(LIMIT));

  assign bcd  = r_bcd;
  assign ovf  = r_ovf;
  assign busy = (r_state != S_IDLE);
  assign seg  = r_seg;
  assign an   = r_an;

  // Converter state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Converter next-state: one SHIFT cycle per input bit, then a single DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (load) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Add-3 correction on every scratch nibble that would overflow after doubling
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < SN; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
    end
  end

  // Converter datapath: capture, shift-and-adjust, publish result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shift    <= value;
            r_scratch  <= '0;
            r_cnt      <= CW'(N);
            r_ovf_pend <= w_ovf_in;
          end
        end
        S_SHIFT: begin
          {r_scratch, r_shift} <= {w_adj[SW-2:0], r_shift, 1'b0};
          r_cnt                <= r_cnt - CW'(1);
        end
        S_DONE: begin
          if (r_ovf_pend) begin
            r_bcd <= {DIGITS{4'h9}};
            r_ovf <= 1'b1;
          end else begin
            r_bcd <= r_scratch[BW-1:0];
            r_ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running prescaler stepping the scan index at terminal count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PW'(SCAN_DIV - 1)) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Leading-zero mask, digit select and segment decode for the active digit
  always_comb begin
    w_zero_run = 1'b1;
    w_lz       = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run & (r_bcd[4*k +: 4] == 4'd0);
      w_lz[k]    = w_zero_run;
    end
    w_nib    = 4'd0;
    w_an_oh  = '0;
    w_cur_lz = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib      = r_bcd[4*k +: 4];
        w_an_oh[k] = 1'b1;
        w_cur_lz   = (k != 0) && w_lz[k];
      end
    end
    if ((BLANK_LZ != 0) && w_cur_lz) begin
      w_seg_hi = 7'h00;
    end else begin
      case (w_nib)
        4'd0:    w_seg_hi = 7'h3F;
        4'd1:    w_seg_hi = 7'h06;
        4'd2:    w_seg_hi = 7'h5B;
        4'd3:    w_seg_hi = 7'h4F;
        4'd4:    w_seg_hi = 7'h66;
        4'd5:    w_seg_hi = 7'h6D;
        4'd6:    w_seg_hi = 7'h7D;
        4'd7:    w_seg_hi = 7'h07;
        4'd8:    w_seg_hi = 7'h7F;
        4'd9:    w_seg_hi = 7'h6F;
        default: w_seg_hi = 7'h00;
      endcase
    end
  end

  // Pin registers with polarity applied; reset shows "0" on digit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= (ACTIVE_LOW != 0) ? ~7'h3F : 7'h3F;
      r_an  <= (ACTIVE_LOW != 0) ? ~DIGITS'(1) : DIGITS'(1);
    end else begin
      r_seg <= (ACTIVE_LOW != 0) ? ~w_seg_hi : w_seg_hi;
      r_an  <= (ACTIVE_LOW != 0) ? ~w_an_oh : w_an_oh;
    end
  end

endmodule

// File: tb/tb_bcd_seg_display.sv
// tb/tb_bcd_seg_display.sv - directed self-checking bench for bcd_seg_display
module tb_bcd_seg_display;

  logic        clk;
  logic        rst;
  logic [7:0]  value;
  logic        load;

  logic [11:0] bcd_a;
  logic        busy_a, ovf_a;
  logic [6:0]  seg_a;
  logic [2:0]  an_a;

  logic [7:0]  bcd_b;
  logic        busy_b, ovf_b;
  logic [6:0]  seg_b;
  logic [1:0]  an_b;

  logic [11:0] bcd_c;
  logic        busy_c, ovf_c;
  logic [6:0]  seg_c;
  logic [2:0]  an_c;

  int total = 0;
  int bad   = 0;

  bcd_seg_display #(.N(8), .DIGITS(3), .SCAN_DIV(4), .ACTIVE_LOW(1), .BLANK_LZ(1)) u_dut_a (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .bcd(bcd_a), .busy(busy_a), .ovf(ovf_a), .seg(seg_a), .an(an_a));

  bcd_seg_display #(.N(8), .DIGITS(2), .SCAN_DIV(4), .ACTIVE_LOW(1), .BLANK_LZ(1)) u_dut_b (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .bcd(bcd_b), .busy(busy_b), .ovf(ovf_b), .seg(seg_b), .an(an_b));

  bcd_seg_display #(.N(8), .DIGITS(3), .SCAN_DIV(4), .ACTIVE_LOW(1), .BLANK_LZ(0)) u_dut_c (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .bcd(bcd_c), .busy(busy_c), .ovf(ovf_c), .seg(seg_c), .an(an_c));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_timeout", {31'd0, busy_a}, 32'd0);
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    wait_idle();
  endtask

  initial begin
    logic [2:0] prev_an;
    logic [2:0] exp_an;
    logic [6:0] exp_seg_a;
    logic [6:0] exp_seg_c;
    int         n;

    clk = 1'b0; rst = 1'b1; load = 1'b0; value = 8'd0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_bcd",  32'(bcd_a), 32'h000);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_ovf",  32'(ovf_a), 32'd0);
    check_eq("rst_an",   32'(an_a), 32'b110);
    check_eq("rst_seg",  32'(seg_a), 32'b1000000);
    check_eq("rst_an_b", 32'(an_b), 32'b10);
    rst = 1'b0;

    // 255: busy for 9 cycles; stray loads in SHIFT and DONE are ignored
    @(negedge clk);
    value = 8'd255;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check_eq("busy_hi", 32'(busy_a), 32'd1);
      if (i == 3) begin value = 8'd17; load = 1'b1; end
      if (i == 4) load = 1'b0;
      if (i == 8) begin value = 8'd17; load = 1'b1; end
      @(negedge clk);
    end
    load = 1'b0;
    check_eq("busy_lo",  32'(busy_a), 32'd0);
    check_eq("bcd_255",  32'(bcd_a), 32'h255);
    check_eq("ovf_255",  32'(ovf_a), 32'd0);
    check_eq("bcd_255b", 32'(bcd_b), 32'h99);
    check_eq("ovf_255b", 32'(ovf_b), 32'd1);
    check_eq("bcd_255c", 32'(bcd_c), 32'h255);
    @(negedge clk);
    check_eq("done_load_ign", 32'(busy_a), 32'd0);
    check_eq("bcd_kept", 32'(bcd_a), 32'h255);

    do_load(8'd17);
    check_eq("bcd_17", 32'(bcd_a), 32'h017);

    do_load(8'd150);
    check_eq("bcd_150b", 32'(bcd_b), 32'h99);
    check_eq("ovf_150b", 32'(ovf_b), 32'd1);
    check_eq("bcd_150",  32'(bcd_a), 32'h150);
    check_eq("ovf_150",  32'(ovf_a), 32'd0);

    do_load(8'd42);
    check_eq("bcd_42b", 32'(bcd_b), 32'h42);
    check_eq("ovf_42b", 32'(ovf_b), 32'd0);

    do_load(8'd99);
    check_eq("bcd_99b", 32'(bcd_b), 32'h99);
    check_eq("ovf_99b", 32'(ovf_b), 32'd0);

    do_load(8'd100);
    check_eq("bcd_100b", 32'(bcd_b), 32'h99);
    check_eq("ovf_100b", 32'(ovf_b), 32'd1);
    check_eq("bcd_100",  32'(bcd_a), 32'h100);

    do_load(8'd0);
    check_eq("bcd_0", 32'(bcd_a), 32'h000);

    // Scan of 007: lock on to the start of a digit-0 window
    do_load(8'd7);
    check_eq("bcd_7", 32'(bcd_a), 32'h007);
    n = 0;
    prev_an = an_a;
    @(negedge clk);
    while (!(prev_an != 3'b110 && an_a == 3'b110) && n < 40) begin
      prev_an = an_a;
      @(negedge clk);
      n++;
    end
    check_eq("scan_sync", 32'(n < 40), 32'd1);
    for (int i = 0; i < 12; i++) begin
      exp_an    = (i < 4) ? 3'b110 : (i < 8) ? 3'b101 : 3'b011;
      exp_seg_a = (i < 4) ? 7'b1111000 : 7'b1111111;
      exp_seg_c = (i < 4) ? 7'b1111000 : 7'b1000000;
      check_eq("scan_an",    32'(an_a), 32'(exp_an));
      check_eq("scan_seg",   32'(seg_a), 32'(exp_seg_a));
      check_eq("scan_seg_c", 32'(seg_c), 32'(exp_seg_c));
      @(negedge clk);
    end
    check_eq("scan_wrap", 32'(an_a), 32'b110);

    // Reset three cycles into a conversion
    @(negedge clk);
    value = 8'd200;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_busy", 32'(busy_a), 32'd0);
    check_eq("mid_rst_bcd",  32'(bcd_a), 32'h000);
    check_eq("mid_rst_bcdb", 32'(bcd_b), 32'h00);
    rst = 1'b0;
    do_load(8'd123);
    check_eq("bcd_123",  32'(bcd_a), 32'h123);
    check_eq("bcd_123b", 32'(bcd_b), 32'h99);
    check_eq("ovf_123b", 32'(ovf_b), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
